// File: rtl/bft_packet_injector_pkg.sv
// Shared leaf packet format for the BFT injector and leaf_interface.
// Field layout: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.
package bft_packet_injector_pkg;

  localparam int PACKET_BITS           = 49;
  localparam int PAYLOAD_BITS          = 32;
  localparam int NUM_LEAF_BITS         = 5;
  localparam int NUM_PORT_BITS         = 4;
  localparam int NUM_ADDR_BITS         = 7;
  localparam int FREESPACE_UPDATE_SIZE = 64;
  localparam int FIFO_DEPTH            = 4;

  localparam int VALID_BIT = PACKET_BITS - 1;
  localparam int LEAF_LSB  = PAYLOAD_BITS + NUM_ADDR_BITS + NUM_PORT_BITS;
  localparam int PORT_LSB  = PAYLOAD_BITS + NUM_ADDR_BITS;
  localparam int ADDR_LSB  = PAYLOAD_BITS;

  // A packet whose addr field is all-ones carries a freespace (credit) update.
  localparam logic [NUM_ADDR_BITS-1:0] CREDIT_ADDR = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_RESEND = 2'd2
  } inj_state_e;

  function automatic logic [PACKET_BITS-1:0] make_packet(
    input logic [NUM_LEAF_BITS-1:0] leaf,
    input logic [NUM_PORT_BITS-1:0] port,
    input logic [NUM_ADDR_BITS-1:0] addr,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    return {1'b1, leaf, port, addr, payload};
  endfunction

endpackage

// File: rtl/bft_packet_injector_fifo.sv
// Small synchronous skid FIFO holding user words until credits allow them out.
module injector_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (rd_en && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/bft_packet_injector.sv
// Transmit endpoint: turns a user word stream into credit-limited BFT packets
// for one destination leaf/port, honouring the switch's resend request.
module bft_packet_injector
  import bft_packet_injector_pkg::*;
(
  input  logic                       clk_bft,
  input  logic                       reset_bft,
  input  logic [NUM_LEAF_BITS-1:0]   dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]   dst_port,
  input  logic [PAYLOAD_BITS-1:0]    din_user,
  input  logic                       din_user_ap_vld,
  output logic                       din_user_ap_ack,
  output logic [PACKET_BITS-1:0]     dout_leaf_injector2bft,
  input  logic [PACKET_BITS-1:0]     din_leaf_bft2injector,
  input  logic                       resend,
  output logic [NUM_ADDR_BITS:0]     credits
);

  localparam int CW = NUM_ADDR_BITS + 1;
  localparam logic [CW:0]   MAX_CREDITS = (CW+1)'(1 << NUM_ADDR_BITS);
  localparam logic [CW-1:0] MAX_UPDATE  = CW'(FREESPACE_UPDATE_SIZE);

  inj_state_e               state_q, state_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic [PACKET_BITS-1:0]   last_q, last_d;
  logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [CW-1:0]            credits_q, credits_d;

  logic                     fifo_full, fifo_empty;
  logic [PAYLOAD_BITS-1:0]  fifo_word;
  logic                     resend_go, send_go, ret_hit;
  logic [CW-1:0]            ret_n;
  logic [CW:0]              credit_sum;
  logic                     unused_din;

  assign din_user_ap_ack = din_user_ap_vld && !fifo_full && !reset_bft;

  injector_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAYLOAD_BITS)
  ) u_fifo (
    .clk     (clk_bft),
    .rst     (reset_bft),
    .wr_en   (din_user_ap_ack),
    .wr_data (din_user),
    .rd_en   (send_go),
    .rd_data (fifo_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Leaf field and upper payload bits of returned packets carry nothing for us.
  assign unused_din = ^{din_leaf_bft2injector[LEAF_LSB +: NUM_LEAF_BITS],
                        din_leaf_bft2injector[PAYLOAD_BITS-1:NUM_ADDR_BITS]};

  always_comb begin
    ret_hit = din_leaf_bft2injector[VALID_BIT] &&
              (din_leaf_bft2injector[PORT_LSB +: NUM_PORT_BITS] == dst_port) &&
              (din_leaf_bft2injector[ADDR_LSB +: NUM_ADDR_BITS] == CREDIT_ADDR);
    ret_n = '0;
    if (ret_hit) begin
      ret_n = {1'b0, din_leaf_bft2injector[NUM_ADDR_BITS-1:0]};
      if (ret_n > MAX_UPDATE) ret_n = MAX_UPDATE;
    end

    resend_go = resend && (state_q == ST_SEND || state_q == ST_RESEND);
    send_go   = !resend_go && !fifo_empty && (credits_q != '0);

    state_d = ST_IDLE;
    dout_d  = '0;
    last_d  = last_q;
    addr_d  = addr_q;
    if (resend_go) begin
      state_d = ST_RESEND;
      dout_d  = last_q;
    end else if (send_go) begin
      state_d = ST_SEND;
      dout_d  = make_packet(dst_leaf, dst_port, addr_q, fifo_word);
      last_d  = dout_d;
      addr_d  = addr_q + NUM_ADDR_BITS'(1);
    end

    // send_go implies credits_q >= 1, so the subtraction never underflows.
    credit_sum = {1'b0, credits_q} + {1'b0, ret_n} - {{CW{1'b0}}, send_go};
    if (credit_sum > MAX_CREDITS) credits_d = MAX_CREDITS[CW-1:0];
    else                          credits_d = credit_sum[CW-1:0];
  end

  always_ff @(posedge clk_bft or posedge reset_bft) begin
    if (reset_bft) begin
      state_q   <= ST_IDLE;
      dout_q    <= '0;
      last_q    <= '0;
      addr_q    <= '0;
      credits_q <= MAX_CREDITS[CW-1:0];
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      credits_q <= credits_d;
    end
  end

  assign dout_leaf_injector2bft = dout_q;
  assign credits                = credits_q;

endmodule
